// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I-side/D-side memory port arbiter.
//   arb_state_t : arbiter sequencing states
//   arb_gnt_t   : which requester owns the current access
//   pick_side   : grant choice from the two requests and the previous grant
package mem_arb_pkg;

    localparam int unsigned ARB_AW      = 32;
    localparam int unsigned ARB_DW      = 32;
    localparam int unsigned ARB_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_t;

    // Single requester wins outright; with both pending, D goes first unless
    // D had the previous access, so the two sides alternate under contention.
    function automatic arb_gnt_t pick_side(input logic i_req, input logic d_req,
                                           input arb_gnt_t last);
        if (d_req && (!i_req || last == GNT_I)) begin
            return GNT_D;
        end
        return GNT_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the core-side (fetch + data) and memory-side handshake signals.
//   slave  : the arbiter's view (core requests and memory responses in)
//   master : the surrounding core/memory view
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;

    logic          err;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_rdata, i_ready, d_rdata, d_ready, err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_rdata, i_ready, d_rdata, d_ready, err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_watchdog.sv
// Counts cycles an access has been outstanding and flags when the budget is used up.
//   clk, reset : clock, async active-low reset
//   clr        : restart the count (new access starting)
//   en         : count this cycle (access outstanding)
//   expired_c  : current cycle is the TIMEOUT-th counted cycle or later
module arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    // Cycles already elapsed before the current one; saturates at TIMEOUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && cnt_q != CW'(TIMEOUT)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired_c = (cnt_q >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (I) and memory-stage (D) requesters.
// Each access runs IDLE -> BUSY -> RESP; RESP drives a one-cycle ready pulse (with err
// if the watchdog aborted it) back to the side that was granted.
//   clk, reset : clock, async active-low reset
//   bus.i_*    : fetch request/address in, read data/ready out
//   bus.d_*    : data request/we/address/wdata in, read data/ready out
//   bus.err    : pulses with ready when the access was aborted
//   bus.mem_*  : memory request/we/address/wdata out, rdata/ack in
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW      = ARB_AW,
    parameter int unsigned DW      = ARB_DW,
    parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);

    arb_state_t    state_q, state_d;
    arb_gnt_t      last_q,  last_d;
    arb_gnt_t      side_q,  side_d;

    logic          mem_req_q,   mem_req_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic          i_ready_q, i_ready_d;
    logic          d_ready_q, d_ready_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          err_q,     err_d;

    logic          wd_clr;
    logic          wd_en;
    logic          wd_expired_c;

    arb_gnt_t      gnt_c;
    logic [DW-1:0] rsp_data_c;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clr       (wd_clr),
        .en        (wd_en),
        .expired_c (wd_expired_c)
    );

    // Next-state, grant and response computation.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        side_d      = side_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        i_rdata_d   = '0;
        d_rdata_d   = '0;
        err_d       = 1'b0;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;

        gnt_c      = pick_side(bus.i_req, bus.d_req, last_q);
        // Stores return zero; aborted accesses return zero as well.
        rsp_data_c = (bus.mem_ack && !mem_we_q) ? bus.mem_rdata : '0;

        case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    side_d    = gnt_c;
                    mem_req_d = 1'b1;
                    wd_clr    = 1'b1;
                    state_d   = BUSY;
                    if (gnt_c == GNT_D) begin
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.i_addr;
                        mem_wdata_d = '0;
                    end
                end
            end

            BUSY: begin
                wd_en = 1'b1;
                // A real acknowledge takes precedence over a same-cycle expiry.
                if (bus.mem_ack || wd_expired_c) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    err_d       = !bus.mem_ack;
                    state_d     = RESP;
                    if (side_q == GNT_D) begin
                        d_ready_d = 1'b1;
                        d_rdata_d = rsp_data_c;
                    end else begin
                        i_ready_d = 1'b1;
                        i_rdata_d = rsp_data_c;
                    end
                end
            end

            RESP: begin
                // Requester still holds req here; grant only from IDLE next cycle.
                last_d  = side_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_q      <= GNT_I;
            side_q      <= GNT_I;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            side_q      <= side_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// randomized requesters and memory checked every cycle against a transaction model.
module tb_mem_port_arbiter;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned TIMEOUT = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        tests = tests + 1;
        if (act !== req) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // One access at a time: it occupies the memory (mem_req high) for `m_waited`
    // cycles until an ack or TIMEOUT cycles, then reports for exactly one cycle.
    bit            m_busy    = 1'b0;
    bit            m_resp    = 1'b0;
    bit            m_side    = 1'b0;   // 1 = D side owns the access
    bit            m_last    = 1'b0;   // 1 = D side had the previous access
    int            m_waited  = 0;
    logic [AW-1:0] m_addr    = '0;
    logic          m_we      = 1'b0;
    logic [DW-1:0] m_wd      = '0;
    logic          e_i_ready = 1'b0;
    logic          e_d_ready = 1'b0;
    logic          e_err     = 1'b0;
    logic [DW-1:0] e_i_rdata = '0;
    logic [DW-1:0] e_d_rdata = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy    <= 1'b0;
            m_resp    <= 1'b0;
            m_last    <= 1'b0;
            e_i_ready <= 1'b0;
            e_d_ready <= 1'b0;
            e_err     <= 1'b0;
            e_i_rdata <= '0;
            e_d_rdata <= '0;
        end else if (m_resp) begin
            m_last    <= m_side;
            m_resp    <= 1'b0;
            e_i_ready <= 1'b0;
            e_d_ready <= 1'b0;
            e_err     <= 1'b0;
            e_i_rdata <= '0;
            e_d_rdata <= '0;
        end else if (m_busy) begin
            m_waited <= m_waited + 1;
            if (bus.mem_ack || (m_waited + 1 == int'(TIMEOUT))) begin
                m_busy    <= 1'b0;
                m_resp    <= 1'b1;
                e_err     <= !bus.mem_ack;
                e_i_ready <= !m_side;
                e_d_ready <= m_side;
                e_i_rdata <= (!m_side && bus.mem_ack && !m_we) ? bus.mem_rdata : '0;
                e_d_rdata <= ( m_side && bus.mem_ack && !m_we) ? bus.mem_rdata : '0;
            end
        end else if (bus.i_req || bus.d_req) begin
            m_busy   <= 1'b1;
            m_waited <= 0;
            if (bus.d_req && !(bus.i_req && m_last)) begin
                m_side <= 1'b1;
                m_addr <= bus.d_addr;
                m_we   <= bus.d_we;
                m_wd   <= bus.d_wdata;
            end else begin
                m_side <= 1'b0;
                m_addr <= bus.i_addr;
                m_we   <= 1'b0;
                m_wd   <= '0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("model_ctl",
            128'({bus.mem_req, bus.i_ready, bus.d_ready, bus.err, bus.i_rdata, bus.d_rdata}),
            128'({m_busy, e_i_ready, e_d_ready, e_err, e_i_rdata, e_d_rdata}));
        if (m_busy) begin
            chk("model_bus",
                128'({bus.mem_we, bus.mem_addr, bus.mem_wdata}),
                128'({m_we, m_addr, m_wd}));
        end
    end

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    bit i_out = 1'b0;
    bit d_out = 1'b0;
    int n;
    int unsigned ack_pct;

    initial begin
        reset         = 1'b0;
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;

        // Reset held with both requests pending: everything stays zero.
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h0000_0100;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0054;
        bus.d_wdata = 32'hDEAD_BEEF;
        repeat (3) wait_neg();
        chk("reset_ctl", 128'({bus.mem_req, bus.mem_we, bus.i_ready, bus.d_ready, bus.err}), 128'(0));
        chk("reset_bus", 128'({bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata}), 128'(0));
        reset = 1'b1;
        wait_neg();

        // Contention: D first (last grant I after reset), then alternating.
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                chk("contend_d_grant", 128'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}),
                    128'({1'b1, 1'b1, 32'h0000_0054, 32'hDEAD_BEEF}));
            end else begin
                chk("contend_i_grant", 128'({bus.mem_req, bus.mem_we, bus.mem_addr}),
                    128'({1'b1, 1'b0, 32'h0000_0100}));
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hA000_0000 + 32'(k);
            wait_neg();
            bus.mem_ack = 1'b0;
            if (k % 2 == 0) begin
                chk("contend_d_ready", 128'({bus.d_ready, bus.i_ready, bus.err, bus.d_rdata}),
                    128'({1'b1, 1'b0, 1'b0, 32'h0}));
            end else begin
                chk("contend_i_ready", 128'({bus.i_ready, bus.d_ready, bus.err, bus.i_rdata}),
                    128'({1'b1, 1'b0, 1'b0, 32'hA000_0000 + 32'(k)}));
            end
            wait_neg();
            chk("resp_then_idle", 128'({bus.mem_req, bus.i_ready, bus.d_ready}), 128'(0));
            if (k < 3) begin
                wait_neg();
            end else begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end
        end
        wait_neg();
        chk("idle_no_req", 128'(bus.mem_req), 128'(0));

        // Single fetch, zero-wait memory.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0040;
        wait_neg();
        chk("fetch_mem_req", 128'({bus.mem_req, bus.mem_we, bus.mem_addr}),
            128'({1'b1, 1'b0, 32'h0000_0040}));
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h2002_0005;
        wait_neg();
        chk("fetch_ready", 128'({bus.i_ready, bus.d_ready, bus.err, bus.i_rdata}),
            128'({1'b1, 1'b0, 1'b0, 32'h2002_0005}));
        bus.mem_ack = 1'b0;
        bus.i_req   = 1'b0;
        wait_neg();
        chk("fetch_after", 128'({bus.i_ready, bus.i_rdata, bus.mem_req}), 128'(0));

        // Load with four wait states: request stable for five cycles.
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0080;
        wait_neg();
        for (int j = 0; j < 5; j++) begin
            chk("wait_stable", 128'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.d_ready}),
                128'({1'b1, 1'b0, 32'h0000_0080, 1'b0}));
            if (j == 4) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'hCAFE_0004;
            end
            wait_neg();
        end
        bus.mem_ack = 1'b0;
        chk("wait_ready", 128'({bus.d_ready, bus.err, bus.d_rdata, bus.mem_req}),
            128'({1'b1, 1'b0, 32'hCAFE_0004, 1'b0}));
        bus.d_req = 1'b0;
        wait_neg();

        // Watchdog abort: no ack ever arrives.
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h0000_0200;
        bus.mem_rdata = 32'h5555_AAAA;
        wait_neg();
        n = 0;
        while (bus.mem_req && n < 40) begin
            n = n + 1;
            wait_neg();
        end
        chk("timeout_len", 128'(n), 128'(TIMEOUT));
        chk("timeout_resp", 128'({bus.i_ready, bus.err, bus.d_ready, bus.i_rdata}),
            128'({1'b1, 1'b1, 1'b0, 32'h0}));
        bus.i_req = 1'b0;
        wait_neg();
        chk("timeout_after", 128'({bus.err, bus.i_ready}), 128'(0));

        // Reset asserted in the middle of a waiting access.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0300;
        wait_neg();
        wait_neg();
        chk("midrst_busy", 128'(bus.mem_req), 128'(1));
        #2 reset = 1'b0;
        #1;
        chk("midrst_drop", 128'({bus.mem_req, bus.mem_addr}), 128'(0));
        wait_neg();
        chk("midrst_noready", 128'({bus.i_ready, bus.d_ready, bus.err}), 128'(0));
        bus.i_req = 1'b0;
        reset     = 1'b1;
        wait_neg();
        wait_neg();
        chk("midrst_idle", 128'({bus.mem_req, bus.i_ready, bus.d_ready, bus.err}), 128'(0));

        // Randomized traffic; some windows starve the memory of acks to hit timeouts.
        ack_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                ack_pct = ((c / 250) % 4 == 3) ? 0 : $urandom_range(20, 90);
            end
            bus.mem_ack   = ($urandom_range(0, 99) < ack_pct);
            bus.mem_rdata = $urandom;

            if (i_out) begin
                if (e_i_ready) begin
                    i_out     = 1'b0;
                    bus.i_req = 1'b0;
                end else if (m_busy && !m_side && $urandom_range(0, 15) == 0) begin
                    bus.i_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                i_out      = 1'b1;
                bus.i_req  = 1'b1;
                bus.i_addr = $urandom;
            end

            if (d_out) begin
                if (e_d_ready) begin
                    d_out     = 1'b0;
                    bus.d_req = 1'b0;
                end else if (m_busy && m_side && $urandom_range(0, 15) == 0) begin
                    bus.d_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                d_out       = 1'b1;
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
            end
            wait_neg();
        end

        bus.i_req   = 1'b0;
        bus.d_req   = 1'b0;
        bus.mem_ack = 1'b0;
        repeat (4) wait_neg();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
